// File: rtl/multi_dma_wr_arb_if.sv
// rtl/multi_dma_wr_arb_if.sv - burst request/response bus between write arbiter and bus interface unit
//
// Purpose: groups the BIU burst-request handshake and the write-response strobe.
// Ports (signals):
//   biu_adr  burst address, low BL+AL bits zero      (arbiter -> BIU)
//   biu_len  constant burst length encoding          (arbiter -> BIU)
//   biu_ch   channel owning the presented burst      (arbiter -> BIU)
//   biu_req  burst request, registered               (arbiter -> BIU)
//   biu_ack  burst accepted while biu_req=1          (BIU -> arbiter)
//   rsp_val  one write response per accepted burst   (BIU -> arbiter)
interface multi_dma_wr_arb_if #(
    parameter int AW   = 32,
    parameter int CW   = 2,
    parameter int LENW = 5
);
    logic [AW-1:0]   biu_adr;
    logic [LENW-1:0] biu_len;
    logic [CW-1:0]   biu_ch;
    logic            biu_req;
    logic            biu_ack;
    logic            rsp_val;

    modport master (output biu_adr, biu_len, biu_ch, biu_req, input biu_ack, rsp_val);
    modport slave  (input biu_adr, biu_len, biu_ch, biu_req, output biu_ack, rsp_val);
endinterface

// File: rtl/multi_dma_wr_arb.sv
// rtl/multi_dma_wr_arb.sv - multi-channel DMA write-burst round-robin arbiter
//
// Purpose: per-channel address/burst-count registers loaded over PIO; issues one
// fixed-length write burst at a time to the BIU for the round-robin winner among
// channels that are running, have a full burst buffered, and fit under the
// outstanding-response limit.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pio_ch              channel addressed by PIO writes/reads
//   pio_adr_we/len_we   load address / burst count of pio_ch from pio_d
//   pio_d               PIO write data
//   pio_adr/len/cst     readback: address, remaining bursts, status word
//   dff_cnt             per-channel FIFO fill level (words)
//   biu                 burst bus (master side)
//   done                per-channel pulse after the final burst is accepted
//   idle                no channel running and no responses outstanding
module multi_dma_wr_arb #(
    parameter int AL        = 2,
    parameter int AW        = 32,
    parameter int BL        = 4,
    parameter int FW        = 6,
    parameter int CH        = 4,
    parameter int CW        = $clog2(CH),
    parameter int LW        = 16,
    parameter int RSP_CNT_W = 4,
    parameter int BLEN_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CW-1:0]        pio_ch,
    input  logic                 pio_adr_we,
    input  logic                 pio_len_we,
    input  logic [31:0]          pio_d,
    output logic [31:0]          pio_adr,
    output logic [31:0]          pio_len,
    output logic [31:0]          pio_cst,
    input  logic [CH-1:0][FW:0]  dff_cnt,
    multi_dma_wr_arb_if.master   biu,
    output logic [CH-1:0]        done,
    output logic                 idle
);
    localparam int SH   = BL + AL;
    localparam int PW   = AW - SH;
    localparam int LENW = BL + 1 - BLEN_TYPE;
    localparam logic [LENW-1:0]      BURST_LEN   = LENW'(BLEN_TYPE == 0 ? 2**BL : 2**BL - 1);
    localparam logic [FW:0]          BURST_WORDS = (FW+1)'(2**BL);
    localparam logic [RSP_CNT_W-1:0] OUT_MAX     = '1;

    typedef enum logic {S_IDLE, S_REQ} state_t;
    state_t state, state_nxt;

    logic [PW-1:0]        adr [CH];
    logic [LW-1:0]        len [CH];
    logic [CH-1:0]        run, elig, pio_sel, ack_sel;
    logic [RSP_CNT_W-1:0] outstanding;
    logic                 rsp_err, ack, rsp_ok, found;
    logic [CW-1:0]        last_grant, win, biu_ch_r;
    logic [PW-1:0]        biu_adr_r;
    logic                 unused_ok;

    // Low pio_d bits are deliberately dropped by the address load.
    assign unused_ok = &{1'b0, pio_d};

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            elig[i]    = run[i] && (dff_cnt[i] >= BURST_WORDS) && (outstanding != OUT_MAX);
            pio_sel[i] = (pio_ch == CW'(i));
            ack_sel[i] = ack && (biu_ch_r == CW'(i));
        end
    end

    // Round-robin: first eligible channel after the last grant, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= CH; k++) begin
            if (!found && elig[CW'((int'(last_grant) + k) % CH)]) begin
                found = 1'b1;
                win   = CW'((int'(last_grant) + k) % CH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found)       state_nxt = S_REQ;
            S_REQ:   if (biu.biu_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        biu.biu_req = (state == S_REQ);
        biu.biu_adr = {biu_adr_r, {SH{1'b0}}};
        biu.biu_len = BURST_LEN;
        biu.biu_ch  = biu_ch_r;
        ack         = (state == S_REQ) && biu.biu_ack;
        rsp_ok      = biu.rsp_val && (outstanding != '0);
        idle        = (run == '0) && (outstanding == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                adr[i] <= '0;
                len[i] <= '0;
            end
            run         <= '0;
            done        <= '0;
            outstanding <= '0;
            rsp_err     <= 1'b0;
            biu_ch_r    <= '0;
            biu_adr_r   <= '0;
            last_grant  <= CW'(CH - 1);
        end else begin
            done <= '0;
            // The presented burst is a snapshot; later PIO writes cannot disturb it.
            if (state == S_IDLE && found) begin
                biu_ch_r   <= win;
                biu_adr_r  <= adr[win];
                last_grant <= win;
            end
            // A PIO write to a register wins over the ack update of that register.
            for (int i = 0; i < CH; i++) begin
                if (pio_adr_we && pio_sel[i])
                    adr[i] <= pio_d[AW-1:SH];
                else if (ack_sel[i])
                    adr[i] <= adr[i] + 1'b1;

                if (pio_len_we && pio_sel[i]) begin
                    len[i] <= pio_d[LW-1:0];
                    run[i] <= (pio_d[LW-1:0] != '0);
                end else if (ack_sel[i] && len[i] != '0) begin
                    // len can already be 0 if the channel was aborted while presented.
                    len[i] <= len[i] - 1'b1;
                    if (len[i] == LW'(1)) begin
                        run[i]  <= 1'b0;
                        done[i] <= 1'b1;
                    end
                end
            end
            case ({ack, rsp_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (biu.rsp_val && outstanding == '0)
                rsp_err <= 1'b1;
        end
    end

    always_comb begin
        pio_adr = '0;
        pio_len = '0;
        pio_cst = '0;
        if (int'(pio_ch) < CH) begin
            pio_adr[AW-1:0]        = {adr[pio_ch], {SH{1'b0}}};
            pio_len[LW-1:0]        = len[pio_ch];
            pio_cst[24 +: FW+1]    = dff_cnt[pio_ch];
        end
        pio_cst[CH-1:0]            = run;
        pio_cst[15]                = rsp_err;
        pio_cst[16 +: RSP_CNT_W]   = outstanding;
    end
endmodule

// File: tb/tb_multi_dma_wr_arb.sv
// tb/tb_multi_dma_wr_arb.sv - directed scoreboard bench for multi_dma_wr_arb
module tb_multi_dma_wr_arb;
    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      pio_ch;
    logic            pio_adr_we, pio_len_we;
    logic [31:0]     pio_d;
    logic [31:0]     pio_adr, pio_len, pio_cst;
    logic [3:0][6:0] dff_cnt;
    logic [3:0]      done;
    logic            idle;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] adr;
    } burst_t;
    burst_t sb[$];

    multi_dma_wr_arb_if #(.AW(32), .CW(2), .LENW(5)) biu();

    multi_dma_wr_arb #(
        .AL(2), .AW(32), .BL(4), .FW(6), .CH(4), .CW(2), .LW(16), .RSP_CNT_W(2), .BLEN_TYPE(0)
    ) dut (
        .clk(clk), .rst(rst),
        .pio_ch(pio_ch), .pio_adr_we(pio_adr_we), .pio_len_we(pio_len_we), .pio_d(pio_d),
        .pio_adr(pio_adr), .pio_len(pio_len), .pio_cst(pio_cst),
        .dff_cnt(dff_cnt), .biu(biu.master), .done(done), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pio_wr(input int ch, input bit is_len, input logic [31:0] d);
        pio_ch     = 2'(ch);
        pio_d      = d;
        pio_adr_we = !is_len;
        pio_len_we = is_len;
        step();
        pio_adr_we = 1'b0;
        pio_len_we = 1'b0;
    endtask

    task automatic rsp();
        biu.rsp_val = 1'b1;
        step();
        biu.rsp_val = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        burst_t e;
        while (biu.biu_req !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        ok = (biu.biu_req === 1'b1);
        chk("req_seen", 64'(biu.biu_req), 64'd1);
        if (ok) begin
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("biu_ch", 64'(biu.biu_ch), 64'(e.ch));
                chk("biu_adr", 64'(biu.biu_adr), 64'(e.adr));
                chk("biu_len", 64'(biu.biu_len), 64'd16);
            end
        end
    endtask

    task automatic serve(input bit abort, output logic [3:0] d);
        bit ok;
        wait_req(ok);
        d = 4'bxxxx;
        if (ok) begin
            biu.biu_ack = 1'b1;
            if (abort) begin
                pio_ch     = biu.biu_ch;
                pio_d      = 32'd0;
                pio_len_we = 1'b1;
            end
            step();
            biu.biu_ack = 1'b0;
            pio_len_we  = 1'b0;
            d = done;
        end
    endtask

    initial begin
        logic [3:0] d;
        bit         ok;
        rst = 1'b1;
        pio_ch = '0; pio_adr_we = 1'b0; pio_len_we = 1'b0; pio_d = '0;
        dff_cnt = '0;
        biu.biu_ack = 1'b0;
        biu.rsp_val = 1'b0;
        step(); step();
        rst = 1'b0;

        chk("rst_req", 64'(biu.biu_req), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_adr", 64'(pio_adr), 64'd0);
        chk("rst_len", 64'(pio_len), 64'd0);
        chk("rst_cst", 64'(pio_cst), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_biu_adr", 64'(biu.biu_adr), 64'd0);

        // ch1: two bursts from 0x1000, low address bits dropped
        dff_cnt[1] = 7'd16;
        pio_wr(1, 0, 32'h0000_1005);
        chk("adr_mask", 64'(pio_adr), 64'h1000);
        sb.push_back('{2'd1, 32'h1000});
        sb.push_back('{2'd1, 32'h1040});
        pio_wr(1, 1, 32'd2);
        serve(0, d);
        chk("done_b1", 64'(d), 64'h0);
        serve(0, d);
        chk("done_b2", 64'(d), 64'h2);
        step();
        chk("done_once", 64'(done), 64'h0);
        chk("ch1_len", 64'(pio_len), 64'd0);
        chk("ch1_adr", 64'(pio_adr), 64'h1080);
        chk("ch1_cst", 64'(pio_cst), 64'h1002_0000);
        rsp(); rsp();
        chk("ch1_idle", 64'(idle), 64'd1);

        // round robin from reset: 0,2,3 with ch1 not running
        dff_cnt = {4{7'd16}};
        rst = 1'b1; step(); rst = 1'b0;
        pio_wr(2, 0, 32'h2000);
        pio_wr(3, 0, 32'h3000);
        sb.push_back('{2'd0, 32'h0000});
        sb.push_back('{2'd2, 32'h2000});
        sb.push_back('{2'd3, 32'h3000});
        pio_wr(0, 1, 32'd1);
        pio_wr(2, 1, 32'd1);
        pio_wr(3, 1, 32'd1);
        serve(0, d); chk("rr_done0", 64'(d), 64'h1);
        serve(0, d); chk("rr_done2", 64'(d), 64'h4);
        serve(0, d); chk("rr_done3", 64'(d), 64'h8);
        rsp(); rsp();
        chk("rr_not_idle", 64'(idle), 64'd0);
        rsp();
        chk("rr_idle", 64'(idle), 64'd1);

        // outstanding limit: 3 acks then stall until a response
        pio_wr(0, 0, 32'h4000);
        for (int i = 0; i < 4; i++) sb.push_back('{2'd0, 32'h4000 + 32'(i) * 32'h40});
        pio_wr(0, 1, 32'd5);
        for (int i = 0; i < 3; i++) begin
            serve(0, d);
            chk("lim_done", 64'(d), 64'h0);
        end
        for (int i = 0; i < 10; i++) step();
        chk("lim_stall", 64'(biu.biu_req), 64'd0);
        chk("lim_cst", 64'(pio_cst), 64'h1003_0001);
        rsp();
        serve(0, d);
        pio_wr(0, 1, 32'd0);
        rsp(); rsp(); rsp();
        chk("lim_idle", 64'(idle), 64'd1);
        chk("lim_adr", 64'(pio_adr), 64'h4100);

        // abort written in the same cycle as the ack
        dff_cnt = {7'd0, 7'd16, 7'd0, 7'd0};
        pio_wr(2, 0, 32'h5000);
        sb.push_back('{2'd2, 32'h5000});
        pio_wr(2, 1, 32'd3);
        serve(1, d);
        chk("abort_done", 64'(d), 64'h0);
        step();
        chk("abort_done_late", 64'(done), 64'h0);
        chk("abort_len", 64'(pio_len), 64'd0);
        chk("abort_adr", 64'(pio_adr), 64'h5040);
        chk("abort_cst", 64'(pio_cst), 64'h1001_0000);
        step(); step();
        chk("abort_no_req", 64'(biu.biu_req), 64'd0);
        rsp();

        // stray response
        rsp();
        chk("err_cst", 64'(pio_cst), 64'h1000_8000);

        // restart from current address, then reset while presenting
        sb.push_back('{2'd2, 32'h5040});
        pio_wr(2, 1, 32'd1);
        wait_req(ok);
        step(); step(); step();
        chk("hold_req", 64'(biu.biu_req), 64'd1);
        chk("hold_adr", 64'(biu.biu_adr), 64'h5040);
        dff_cnt = '0;
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_req", 64'(biu.biu_req), 64'd0);
        chk("mid_rst_adr", 64'(pio_adr), 64'd0);
        chk("mid_rst_len", 64'(pio_len), 64'd0);
        chk("mid_rst_cst", 64'(pio_cst), 64'd0);
        chk("mid_rst_idle", 64'(idle), 64'd1);
        chk("mid_rst_biu_adr", 64'(biu.biu_adr), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
